// File: rtl/usc_pkg.sv
// rtl/usc_pkg.sv - shared mode and cell-select encodings for universal_shift_counter
//
// Purpose:
//   Operation encodings seen on io_mode, plus the per-bit select that the
//   top level hands to each usc_bit_cell after resolving clear/enable/mode
//   priority.
package usc_pkg;

    // Operation select on io_mode. Codes 6 and 7 are reserved and hold.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_UP   = 3'd4,
        MODE_DOWN = 3'd5
    } usc_mode_e;

    // Next-state source for one bit cell, after priority resolution.
    typedef enum logic [2:0] {
        CELL_HOLD  = 3'd0,
        CELL_LOAD  = 3'd1,
        CELL_LEFT  = 3'd2,   // take lower neighbour (shift left)
        CELL_RIGHT = 3'd3,   // take upper neighbour (shift right)
        CELL_COUNT = 3'd4,   // take bit of the +1/-1 vector
        CELL_CLEAR = 3'd5    // take the per-bit reset value
    } usc_cell_sel_e;

endpackage

// File: rtl/usc_bit_cell.sv
// rtl/usc_bit_cell.sv - one bit of the universal shift counter: next-state mux plus flop
//
// Purpose:
//   Selects the next value of a single register bit and stores it. The flop
//   resets asynchronously to RESET_BIT, the same value a sync clear loads.
//
// Ports:
//   clock        rising-edge clock
//   resetNegate  asynchronous active-low reset
//   sel_i        next-state source (usc_cell_sel_e)
//   data_i       parallel load bit
//   left_i       lower neighbour bit (or serial-in at bit 0) for shift left
//   right_i      upper neighbour bit (or serial-in at MSB) for shift right
//   count_i      this bit of the increment/decrement result
//   q_o          stored bit
module usc_bit_cell
    import usc_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic          clock,
    input  logic          resetNegate,
    input  usc_cell_sel_e sel_i,
    input  logic          data_i,
    input  logic          left_i,
    input  logic          right_i,
    input  logic          count_i,
    output logic          q_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        case (sel_i)
            CELL_HOLD:  bit_d = bit_q;
            CELL_LOAD:  bit_d = data_i;
            CELL_LEFT:  bit_d = left_i;
            CELL_RIGHT: bit_d = right_i;
            CELL_COUNT: bit_d = count_i;
            CELL_CLEAR: bit_d = RESET_BIT;
            default:    bit_d = bit_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetNegate) begin
        if (!resetNegate) begin
            bit_q <= RESET_BIT;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_o = bit_q;

endmodule

// File: rtl/universal_shift_counter.sv
// rtl/universal_shift_counter.sv - WIDTH-bit register with hold/load/shift/count modes
//
// Purpose:
//   General-purpose state element: per-cycle choice of hold, parallel load,
//   shift left, shift right, count up or count down, with a synchronous
//   clear and asynchronous active-low reset, both to RESET_VALUE.
//   Priority at each edge: reset, syncClear, enable low (hold), io_mode.
//
// Ports:
//   clock             rising-edge clock
//   resetNegate       asynchronous active-low reset
//   io_syncClear      synchronous clear, overrides enable and mode
//   io_enable         0 = hold (syncClear still acts)
//   io_mode           operation select (usc_mode_e; 6/7 hold)
//   io_data           parallel load value
//   io_serialInLsb    bit entering bit 0 on shift left
//   io_serialInMsb    bit entering bit WIDTH-1 on shift right
//   io_q              register contents
//   io_serialOutMsb   io_q[WIDTH-1]
//   io_serialOutLsb   io_q[0]
//   io_terminalCount  high in the cycle before an up/down wrap; drives the
//                     enable of the next stage when cascading
module universal_shift_counter
    import usc_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             resetNegate,
    input  logic             io_syncClear,
    input  logic             io_enable,
    input  logic [2:0]       io_mode,
    input  logic [WIDTH-1:0] io_data,
    input  logic             io_serialInLsb,
    input  logic             io_serialInMsb,
    output logic [WIDTH-1:0] io_q,
    output logic             io_serialOutMsb,
    output logic             io_serialOutLsb,
    output logic             io_terminalCount
);

    usc_mode_e        mode;
    usc_cell_sel_e    cell_sel;
    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] count_vec;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;
    logic             q_all_ones;
    logic             q_all_zero;

    assign mode = usc_mode_e'(io_mode);

    // Resolve the priority chain once; every cell sees the same select.
    always_comb begin
        cell_sel = CELL_HOLD;
        if (io_syncClear) begin
            cell_sel = CELL_CLEAR;
        end else if (io_enable) begin
            case (mode)
                MODE_LOAD: cell_sel = CELL_LOAD;
                MODE_SHL:  cell_sel = CELL_LEFT;
                MODE_SHR:  cell_sel = CELL_RIGHT;
                MODE_UP:   cell_sel = CELL_COUNT;
                MODE_DOWN: cell_sel = CELL_COUNT;
                default:   cell_sel = CELL_HOLD;
            endcase
        end
    end

    // Single adder shared by both count directions; only consulted by the
    // cells when the select is CELL_COUNT, so non-count modes don't care.
    always_comb begin
        count_vec = q_vec + {{(WIDTH-1){1'b0}}, 1'b1};
        if (mode == MODE_DOWN) begin
            count_vec = q_vec - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign shl_vec = {q_vec[WIDTH-2:0], io_serialInLsb};
    assign shr_vec = {io_serialInMsb, q_vec[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usc_bit_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clock       (clock),
            .resetNegate (resetNegate),
            .sel_i       (cell_sel),
            .data_i      (io_data[i]),
            .left_i      (shl_vec[i]),
            .right_i     (shr_vec[i]),
            .count_i     (count_vec[i]),
            .q_o         (q_vec[i])
        );
    end

    assign q_all_ones = &q_vec;
    assign q_all_zero = ~|q_vec;

    // Combinational so a cascaded higher stage is enabled in the same cycle
    // the lower stage wraps.
    assign io_terminalCount = io_enable & ~io_syncClear &
                              (((mode == MODE_UP)   & q_all_ones) |
                               ((mode == MODE_DOWN) & q_all_zero));

    assign io_q            = q_vec;
    assign io_serialOutMsb = q_vec[WIDTH-1];
    assign io_serialOutLsb = q_vec[0];

endmodule

// File: tb/tb_universal_shift_counter.sv
// tb/tb_universal_shift_counter.sv - self-checking bench for universal_shift_counter
module tb_universal_shift_counter;

    logic       clock;
    logic       resetNegate;
    logic       syncClear;
    logic       enable;
    logic [2:0] mode;
    logic [7:0] data;
    logic       sinLsb;
    logic       sinMsb;
    logic [7:0] q;
    logic       soutMsb;
    logic       soutLsb;
    logic       tc;

    // cascade pair
    logic [2:0] c_mode;
    logic [7:0] c_lo_data;
    logic [7:0] c_hi_data;
    logic       c_hi_force;
    logic [7:0] c_lo_q;
    logic [7:0] c_hi_q;
    logic       c_lo_tc;
    logic       c_hi_tc;
    logic       c_hi_en;
    logic       c_lo_smsb, c_lo_slsb, c_hi_smsb, c_hi_slsb;

    assign c_hi_en = c_hi_force | c_lo_tc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       clr;
        logic       en;
        logic [2:0] mode;
        logic [7:0] data;
        logic       lsb;
        logic       msb;
        logic       exp_tc;   // terminalCount before the edge
        logic [7:0] exp_q;    // io_q after the edge
    } vec_t;

    vec_t       vecs[21];
    logic [7:0] sb[$];

    universal_shift_counter #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clock            (clock),
        .resetNegate      (resetNegate),
        .io_syncClear     (syncClear),
        .io_enable        (enable),
        .io_mode          (mode),
        .io_data          (data),
        .io_serialInLsb   (sinLsb),
        .io_serialInMsb   (sinMsb),
        .io_q             (q),
        .io_serialOutMsb  (soutMsb),
        .io_serialOutLsb  (soutLsb),
        .io_terminalCount (tc)
    );

    universal_shift_counter #(.WIDTH(8), .RESET_VALUE(8'h00)) c_lo (
        .clock            (clock),
        .resetNegate      (resetNegate),
        .io_syncClear     (1'b0),
        .io_enable        (1'b1),
        .io_mode          (c_mode),
        .io_data          (c_lo_data),
        .io_serialInLsb   (1'b0),
        .io_serialInMsb   (1'b0),
        .io_q             (c_lo_q),
        .io_serialOutMsb  (c_lo_smsb),
        .io_serialOutLsb  (c_lo_slsb),
        .io_terminalCount (c_lo_tc)
    );

    universal_shift_counter #(.WIDTH(8), .RESET_VALUE(8'h00)) c_hi (
        .clock            (clock),
        .resetNegate      (resetNegate),
        .io_syncClear     (1'b0),
        .io_enable        (c_hi_en),
        .io_mode          (c_mode),
        .io_data          (c_hi_data),
        .io_serialInLsb   (1'b0),
        .io_serialInMsb   (1'b0),
        .io_q             (c_hi_q),
        .io_serialOutMsb  (c_hi_smsb),
        .io_serialOutLsb  (c_hi_slsb),
        .io_terminalCount (c_hi_tc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required end before 100000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Pop one scoreboard entry and compare it against the DUT register.
    task automatic compare_q(input string name);
        logic [7:0] e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got 0x%0h, required an entry", name, q);
        end else begin
            e = sb.pop_front();
            check({name, " q"}, {24'd0, q}, {24'd0, e});
            check({name, " msb"}, {31'd0, soutMsb}, {31'd0, e[7]});
            check({name, " lsb"}, {31'd0, soutLsb}, {31'd0, e[0]});
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clock);
        syncClear = v.clr;
        enable    = v.en;
        mode      = v.mode;
        data      = v.data;
        sinLsb    = v.lsb;
        sinMsb    = v.msb;
        #1;
        check({tag, " tc"}, {31'd0, tc}, {31'd0, v.exp_tc});
        sb.push_back(v.exp_q);
        @(posedge clock);
        #1;
        compare_q(tag);
    endtask

    initial begin
        // clr en mode data lsb msb tc q
        vecs[0]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81}; // LOAD 81
        vecs[1]  = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03}; // SHL in 1
        vecs[2]  = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01}; // SHR in 0
        vecs[3]  = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h80}; // SHR in 1
        vecs[4]  = '{1'b0, 1'b1, 3'd1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFE}; // LOAD FE
        vecs[5]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF}; // UP
        vecs[6]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00}; // UP wrap
        vecs[7]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01}; // UP
        vecs[8]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}; // DOWN
        vecs[9]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF}; // DOWN wrap
        vecs[10] = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE}; // SHL in 0
        vecs[11] = '{1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF}; // LOAD FF
        vecs[12] = '{1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF}; // UP en=0
        vecs[13] = '{1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}; // clr beats UP
        vecs[14] = '{1'b0, 1'b1, 3'd1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h40}; // LOAD 40
        vecs[15] = '{1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40}; // en=0 hold
        vecs[16] = '{1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}; // clr en=0
        vecs[17] = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF}; // DOWN wrap
        vecs[18] = '{1'b0, 1'b1, 3'd6, 8'h12, 1'b1, 1'b1, 1'b0, 8'hFF}; // reserved 6
        vecs[19] = '{1'b0, 1'b1, 3'd7, 8'h34, 1'b1, 1'b1, 1'b0, 8'hFF}; // reserved 7
        vecs[20] = '{1'b0, 1'b1, 3'd0, 8'h56, 1'b0, 1'b0, 1'b0, 8'hFF}; // HOLD

        resetNegate = 1'b0;
        syncClear   = 1'b0;
        enable      = 1'b1;
        mode        = 3'd5;
        data        = 8'h00;
        sinLsb      = 1'b0;
        sinMsb      = 1'b0;
        c_mode      = 3'd0;
        c_lo_data   = 8'h00;
        c_hi_data   = 8'h00;
        c_hi_force  = 1'b0;

        // reset state, and terminalCount from q=0 with DOWN enabled
        #3;
        check("reset q", {24'd0, q}, 32'h00);
        check("reset tc down", {31'd0, tc}, 32'd1);
        @(posedge clock);
        #1;
        check("reset held q", {24'd0, q}, 32'h00);
        @(negedge clock);
        resetNegate = 1'b1;
        mode        = 3'd0;

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i], i);
        end

        // async reset mid-cycle aborts a count with no clock edge
        apply('{1'b0, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A}, 100);
        @(negedge clock);
        mode = 3'd4;
        #2;
        resetNegate = 1'b0;
        #1;
        check("async reset q", {24'd0, q}, 32'h00);
        @(posedge clock);
        #1;
        check("reset low across edge q", {24'd0, q}, 32'h00);
        @(negedge clock);
        resetNegate = 1'b1;
        sb.push_back(8'h01);           // first UP after release starts at 0
        @(posedge clock);
        #1;
        compare_q("release up");
        apply('{1'b0, 1'b1, 3'd1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hC3}, 101);

        // cascade: 0x00FF + 1 -> 0x0100 in one cycle
        @(negedge clock);
        c_mode     = 3'd1;
        c_lo_data  = 8'hFF;
        c_hi_data  = 8'h00;
        c_hi_force = 1'b1;
        @(posedge clock);
        #1;
        check("cascade load", {16'd0, c_hi_q, c_lo_q}, 32'h00FF);
        @(negedge clock);
        c_mode     = 3'd4;
        c_hi_force = 1'b0;
        #1;
        check("cascade lo tc", {31'd0, c_lo_tc}, 32'd1);
        check("cascade hi tc", {31'd0, c_hi_tc}, 32'd0);
        @(posedge clock);
        #1;
        check("cascade carry", {16'd0, c_hi_q, c_lo_q}, 32'h0100);
        @(negedge clock);
        #1;
        check("cascade lo tc after", {31'd0, c_lo_tc}, 32'd0);
        @(posedge clock);
        #1;
        check("cascade next", {16'd0, c_hi_q, c_lo_q}, 32'h0101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
